// File: rtl/boot_pkg.sv
// Shared definitions for the UART boot loader: FSM state encoding and the
// default frame start marker.
package boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } boot_state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/boot_timeout.sv
// Inter-byte watchdog: a loadable down-counter that reloads on clear and
// flags expiry once it has run down while enabled.
module boot_timeout #(
  parameter int TIMEOUT = 1000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Clear wins over counting so a byte arriving at expiry restarts the window.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= '0;
    end else if (i_clear) begin
      count <= LOAD;
    end else if (i_enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign o_expire = i_enable && (count == '0);

endmodule

// File: rtl/uart_boot_loader.sv
// Receives a framed program image over the UART byte stream, writes it into
// BRAM port B and releases the CPU only after a checksum-verified frame.
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int         ADDR_W    = 13,
  parameter int         TIMEOUT   = 1000000,
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_skip,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_data,
  output logic [3:0]        o_mem_wr,
  output logic              o_cpu_rst,
  output logic              o_busy,
  output logic              o_error
);

  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

  boot_state_t     state;
  logic [15:0]     len;
  logic [ADDR_W:0] word_cnt;
  logic [ADDR_W:0] word_cnt_nxt;
  logic [1:0]      idx;
  logic [23:0]     word_lo;
  logic [7:0]      csum;
  logic [15:0]     len_full;
  logic            len_too_big;
  logic            last_word;
  logic            to_active;
  logic            to_clear;
  logic            to_expire;

  assign len_full     = {i_rx_data, len[7:0]};
  assign len_too_big  = (32'(len_full) > MAX_WORDS);
  assign word_cnt_nxt = word_cnt + (ADDR_W+1)'(1);
  assign last_word    = (32'(word_cnt_nxt) == 32'(len));

  // The watchdog only runs while a frame is open; outside it stays loaded.
  assign to_active = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                     (state == ST_DATA)   || (state == ST_CSUM);
  assign to_clear  = i_rx_valid || !to_active;

  boot_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (to_clear),
    .i_enable (to_active),
    .o_expire (to_expire)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      len        <= '0;
      word_cnt   <= '0;
      idx        <= '0;
      word_lo    <= '0;
      csum       <= '0;
      o_mem_addr <= '0;
      o_mem_data <= '0;
      o_mem_wr   <= '0;
      o_cpu_rst  <= 1'b1;
      o_busy     <= 1'b0;
      o_error    <= 1'b0;
    end else begin
      o_mem_wr <= '0;
      case (state)
        ST_IDLE: begin
          if (i_skip) begin
            state     <= ST_DONE;
            o_cpu_rst <= 1'b0;
          end else if (i_rx_valid && (i_rx_data == SYNC_BYTE)) begin
            state   <= ST_LEN_LO;
            o_error <= 1'b0;
            csum    <= '0;
            o_busy  <= 1'b1;
          end
        end
        ST_LEN_LO: begin
          if (i_rx_valid) begin
            len[7:0] <= i_rx_data;
            state    <= ST_LEN_HI;
          end else if (to_expire) begin
            state   <= ST_ERR;
            o_error <= 1'b1;
            o_busy  <= 1'b0;
          end
        end
        ST_LEN_HI: begin
          if (i_rx_valid) begin
            len[15:8] <= i_rx_data;
            if (len_too_big) begin
              state   <= ST_ERR;
              o_error <= 1'b1;
              o_busy  <= 1'b0;
            end else if (len_full == 16'd0) begin
              state <= ST_CSUM;
            end else begin
              state    <= ST_DATA;
              word_cnt <= '0;
              idx      <= '0;
            end
          end else if (to_expire) begin
            state   <= ST_ERR;
            o_error <= 1'b1;
            o_busy  <= 1'b0;
          end
        end
        // Bytes arrive LSB first; the fourth byte completes the word and
        // launches the write directly from the incoming byte.
        ST_DATA: begin
          if (i_rx_valid) begin
            csum <= csum + i_rx_data;
            case (idx)
              2'd0: word_lo[7:0]   <= i_rx_data;
              2'd1: word_lo[15:8]  <= i_rx_data;
              2'd2: word_lo[23:16] <= i_rx_data;
              default: begin
                o_mem_wr   <= 4'hF;
                o_mem_data <= {i_rx_data, word_lo};
                o_mem_addr <= word_cnt[ADDR_W-1:0];
                word_cnt   <= word_cnt_nxt;
                if (last_word) begin
                  state <= ST_CSUM;
                end
              end
            endcase
            idx <= idx + 2'd1;
          end else if (to_expire) begin
            state   <= ST_ERR;
            o_error <= 1'b1;
            o_busy  <= 1'b0;
          end
        end
        ST_CSUM: begin
          if (i_rx_valid) begin
            o_busy <= 1'b0;
            if (i_rx_data == csum) begin
              state     <= ST_DONE;
              o_cpu_rst <= 1'b0;
            end else begin
              state   <= ST_ERR;
              o_error <= 1'b1;
            end
          end else if (to_expire) begin
            state   <= ST_ERR;
            o_error <= 1'b1;
            o_busy  <= 1'b0;
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        ST_ERR: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
